// File: rtl/lcd_show_char.sv
`default_nettype none
// ============================================================================
// Module   : lcd_show_char
// Purpose  : Fetches the rows of one font glyph and streams one RGB565 pixel per
//            glyph cell on a valid/ready interface.
// Revision : 1.0
// ============================================================================
module lcd_show_char #(
    parameter logic [15:0] FG_COLOR = 16'h0000,
    parameter logic [15:0] BG_COLOR = 16'hFFFF
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        show_char_flag,
    input  logic [6:0]  ascii_num,
    input  logic [8:0]  start_x,
    input  logic [8:0]  start_y,
    input  logic        en_size,
    output logic [10:0] rom_addr,
    output logic        rom_sel,
    input  logic [7:0]  rom_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic [8:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic [15:0] pix_color,
    output logic        show_char_done,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_PIXEL = 3'd3,
        S_DONE  = 3'd4,
        S_GAP   = 3'd5
    } state_t;

    state_t      r_state;
    logic [8:0]  r_start_x;
    logic [8:0]  r_start_y;
    logic [3:0]  r_row;
    logic [2:0]  r_col;
    logic [7:0]  r_shift;

    logic [6:0]  w_idx;
    logic [10:0] w_base_small;
    logic [10:0] w_base_large;
    logic [10:0] w_base;
    logic [2:0]  w_last_col;
    logic [3:0]  w_last_row;
    logic        w_xfer;

    // Indices past the last printable glyph fall back to the space glyph.
    assign w_idx        = (ascii_num > 7'd94) ? 7'd0 : ascii_num;
    assign w_base_small = ({4'b0, w_idx} << 3) + ({4'b0, w_idx} << 2);
    assign w_base_large = {w_idx, 4'b0};
    assign w_base       = en_size ? w_base_large : w_base_small;
    assign w_last_col   = rom_sel ? 3'd7 : 3'd5;
    assign w_last_row   = rom_sel ? 4'd15 : 4'd11;
    assign w_xfer       = pix_valid & pix_ready;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state        <= S_IDLE;
            r_start_x      <= 9'd0;
            r_start_y      <= 9'd0;
            r_row          <= 4'd0;
            r_col          <= 3'd0;
            r_shift        <= 8'd0;
            rom_addr       <= 11'd0;
            rom_sel        <= 1'b0;
            pix_valid      <= 1'b0;
            pix_x          <= 9'd0;
            pix_y          <= 9'd0;
            pix_color      <= 16'd0;
            show_char_done <= 1'b0;
            busy           <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (show_char_flag) begin
                        r_start_x <= start_x;
                        r_start_y <= start_y;
                        rom_sel   <= en_size;
                        rom_addr  <= w_base;
                        r_row     <= 4'd0;
                        busy      <= 1'b1;
                        r_state   <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // Column 0 is presented straight from the ROM; the rest shift out of bit 7.
                    pix_valid <= 1'b1;
                    pix_x     <= r_start_x;
                    pix_y     <= r_start_y + {5'b0, r_row};
                    pix_color <= rom_data[7] ? FG_COLOR : BG_COLOR;
                    r_shift   <= {rom_data[6:0], 1'b0};
                    r_col     <= 3'd0;
                    r_state   <= S_PIXEL;
                end
                S_PIXEL: begin
                    if (w_xfer) begin
                        if (r_col != w_last_col) begin
                            r_col     <= r_col + 3'd1;
                            pix_x     <= pix_x + 9'd1;
                            pix_color <= r_shift[7] ? FG_COLOR : BG_COLOR;
                            r_shift   <= {r_shift[6:0], 1'b0};
                        end else begin
                            pix_valid <= 1'b0;
                            if (r_row != w_last_row) begin
                                r_row    <= r_row + 4'd1;
                                rom_addr <= rom_addr + 11'd1;
                                r_state  <= S_FETCH;
                            end else begin
                                show_char_done <= 1'b1;
                                r_state        <= S_DONE;
                            end
                        end
                    end
                end
                S_DONE: begin
                    show_char_done <= 1'b0;
                    r_state        <= S_GAP;
                end
                S_GAP: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lcd_show_char.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_show_char
// Purpose  : Self-checking bench for lcd_show_char against a glyph-level model.
// Revision : 1.0
// ============================================================================
module tb_lcd_show_char;

    logic        sys_clk;
    logic        sys_rst;
    logic        show_char_flag;
    logic [6:0]  ascii_num;
    logic [8:0]  start_x;
    logic [8:0]  start_y;
    logic        en_size;
    logic [10:0] rom_addr;
    logic        rom_sel;
    logic [7:0]  rom_data;
    logic        pix_valid;
    logic        pix_ready;
    logic [8:0]  pix_x;
    logic [8:0]  pix_y;
    logic [15:0] pix_color;
    logic        show_char_done;
    logic        busy;

    int checks = 0;
    int errors = 0;

    int ex [128];
    int ey [128];
    int ec [128];
    int ea [128];

    typedef struct {
        int idx;
        int sx;
        int sy;
        int sz;
        int rmode;
        int noise;
        int exp_addr0;
        int exp_done;
    } vec_t;

    vec_t tbl [8];

    lcd_show_char dut (
        .sys_clk        (sys_clk),
        .sys_rst        (sys_rst),
        .show_char_flag (show_char_flag),
        .ascii_num      (ascii_num),
        .start_x        (start_x),
        .start_y        (start_y),
        .en_size        (en_size),
        .rom_addr       (rom_addr),
        .rom_sel        (rom_sel),
        .rom_data       (rom_data),
        .pix_valid      (pix_valid),
        .pix_ready      (pix_ready),
        .pix_x          (pix_x),
        .pix_y          (pix_y),
        .pix_color      (pix_color),
        .show_char_done (show_char_done),
        .busy           (busy)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    function automatic logic [7:0] rom_fn(input logic sel, input logic [10:0] a);
        int v;
        v = int'(a) * 29 + (sel ? 113 : 7);
        return 8'(v) ^ a[10:3];
    endfunction

    // Synchronous font ROM: data follows the sampled address by one cycle.
    always @(posedge sys_clk) rom_data <= rom_fn(rom_sel, rom_addr);

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_rom_addr"}, rom_addr, 0);
        chk({nm, "_rom_sel"}, rom_sel, 0);
        chk({nm, "_pix_valid"}, pix_valid, 0);
        chk({nm, "_pix_x"}, pix_x, 0);
        chk({nm, "_pix_y"}, pix_y, 0);
        chk({nm, "_pix_color"}, pix_color, 0);
        chk({nm, "_done"}, show_char_done, 0);
        chk({nm, "_busy"}, busy, 0);
    endtask

    task automatic run_char(input int idx, input int sx, input int sy, input int sz,
                            input int rmode, input int noise, input int abort_at,
                            output int done_k, output int stalls, output int addr0);
        int eidx, hh, ww, base, total, n, k, bubble, prev_stall, px, py, pc;
        bit rdy, any;
        eidx  = (idx > 94) ? 0 : idx;
        hh    = sz ? 16 : 12;
        ww    = sz ? 8 : 6;
        base  = sz ? eidx * 16 : eidx * 12;
        total = hh * ww;
        for (int r = 0; r < hh; r++) begin
            for (int c = 0; c < ww; c++) begin
                logic [7:0] d;
                d = rom_fn(sz[0], 11'(base + r));
                ex[r*ww+c] = (sx + c) % 512;
                ey[r*ww+c] = (sy + r) % 512;
                ec[r*ww+c] = d[7-c] ? 16'h0000 : 16'hFFFF;
                ea[r*ww+c] = base + r;
            end
        end
        ascii_num      = 7'(idx);
        start_x        = 9'(sx);
        start_y        = 9'(sy);
        en_size        = sz[0];
        show_char_flag = 1'b1;
        pix_ready      = 1'b0;
        @(posedge sys_clk);
        #1;
        show_char_flag = 1'b0;
        ascii_num      = 7'($urandom);
        start_x        = 9'($urandom);
        start_y        = 9'($urandom);
        en_size        = ~en_size;
        n = 0; k = 0; stalls = 0; bubble = 2; prev_stall = 0;
        done_k = -1; addr0 = -1; px = 0; py = 0; pc = 0;
        while (1) begin
            @(negedge sys_clk);
            if (abort_at >= 0 && n == abort_at) begin
                sys_rst        = 1'b1;
                show_char_flag = 1'b1;
                pix_ready      = 1'b0;
                @(negedge sys_clk);
                chk_zero("abort");
                @(negedge sys_clk);
                sys_rst        = 1'b0;
                show_char_flag = 1'b0;
                any = 0;
                repeat (120) begin
                    @(negedge sys_clk);
                    if (show_char_done || busy) any = 1;
                end
                chk("abort_quiet", any, 0);
                return;
            end
            if (k == 0) begin
                addr0 = rom_addr;
                chk("busy_rise", busy, 1);
                chk("rom_sel", rom_sel, sz);
            end
            if (show_char_done) begin
                done_k = k;
                break;
            end
            if (k > 400) begin
                chk("done_seen", show_char_done, 1);
                break;
            end
            if (noise != 0) begin
                show_char_flag = (k % 4 == 0);
                ascii_num      = 7'($urandom);
                start_x        = 9'($urandom);
                start_y        = 9'($urandom);
            end
            if (bubble > 0) begin
                chk("bubble_valid", pix_valid, 0);
                bubble--;
                pix_ready = 1'($urandom);
            end else if (n >= total) begin
                chk("extra_pixel", pix_valid, 0);
            end else begin
                chk("pix_valid", pix_valid, 1);
                if (pix_valid) begin
                    if (prev_stall != 0) begin
                        chk("stall_x", pix_x, px);
                        chk("stall_y", pix_y, py);
                        chk("stall_color", pix_color, pc);
                    end
                    chk("pix_x", pix_x, ex[n]);
                    chk("pix_y", pix_y, ey[n]);
                    chk("pix_color", pix_color, ec[n]);
                    chk("rom_addr", rom_addr, ea[n]);
                    rdy = (rmode != 0) ? 1'($urandom) : 1'b1;
                    pix_ready = rdy;
                    if (rdy) begin
                        n++;
                        prev_stall = 0;
                        if (n % ww == 0) bubble = 2;
                    end else begin
                        stalls++;
                        prev_stall = 1;
                        px = pix_x;
                        py = pix_y;
                        pc = pix_color;
                    end
                end
            end
            k++;
        end
        show_char_flag = (noise != 0);
        pix_ready = 1'b0;
        if (done_k >= 0) begin
            chk("done_time", done_k - stalls, hh * (ww + 2));
            chk("pixels", n, total);
            chk("busy_done", busy, 1);
        end
        @(negedge sys_clk);
        chk("done_width", show_char_done, 0);
        chk("busy_gap", busy, 1);
        @(negedge sys_clk);
        chk("busy_idle", busy, 0);
        chk("done_idle", show_char_done, 0);
        show_char_flag = 1'b0;
    endtask

    initial begin
        int dk, st, a0;
        sys_rst        = 1'b1;
        show_char_flag = 1'b1;
        ascii_num      = 7'd33;
        start_x        = 9'd5;
        start_y        = 9'd5;
        en_size        = 1'b1;
        pix_ready      = 1'b1;

        tbl[0] = '{82,   8,  48, 0, 0, 0,  984,  96};
        tbl[1] = '{33,  72,  16, 1, 0, 0,  528, 160};
        tbl[2] = '{82,   8,  48, 0, 1, 0,  984,  96};
        tbl[3] = '{33,  72,  16, 1, 1, 1,  528, 160};
        tbl[4] = '{100, 20,  30, 0, 0, 1,    0,  96};
        tbl[5] = '{127,  0,   0, 1, 1, 0,    0, 160};
        tbl[6] = '{1,  508, 100, 0, 0, 0,   12,  96};
        tbl[7] = '{94, 505, 508, 1, 1, 1, 1504, 160};

        repeat (3) begin
            @(negedge sys_clk);
            chk_zero("reset");
        end
        sys_rst        = 1'b0;
        show_char_flag = 1'b0;
        pix_ready      = 1'b0;
        @(negedge sys_clk);
        chk("reset_flag_ignored", busy, 0);

        for (int i = 0; i < 8; i++) begin
            run_char(tbl[i].idx, tbl[i].sx, tbl[i].sy, tbl[i].sz,
                     tbl[i].rmode, tbl[i].noise, -1, dk, st, a0);
            chk($sformatf("tbl%0d_addr0", i), a0, tbl[i].exp_addr0);
            chk($sformatf("tbl%0d_done", i), dk - st, tbl[i].exp_done);
        end

        for (int i = 0; i < 6; i++) begin
            run_char(int'($urandom_range(0, 127)), int'($urandom_range(0, 511)),
                     int'($urandom_range(0, 511)), int'($urandom_range(0, 1)),
                     1, 1, -1, dk, st, a0);
        end

        run_char(82, 8, 48, 0, 0, 0, 30, dk, st, a0);
        run_char(33, 72, 16, 1, 0, 0, -1, dk, st, a0);
        chk("recover_done", dk, 160);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
